// File: rtl/operand_pair_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_pair_collector_pkg
// Description : Shared definitions for the operand pair collector: lane width,
//               lane-valid state encodings, lane selects, stall counter limits.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_pair_collector_pkg;

    localparam int unsigned DATA_W_DEF = 24;

    // Bit 0 = lane A valid, bit 1 = lane B valid.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        HAVE_A = 2'b01,
        HAVE_B = 2'b10,
        FULL   = 2'b11
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int unsigned       STALL_W   = 16;
    localparam logic [STALL_W-1:0] STALL_SAT = 16'hFFFF;

endpackage : operand_pair_collector_pkg
`default_nettype wire

// File: rtl/operand_pair_collector_lane_reg.sv
`default_nettype none
// ============================================================================
// Module      : operand_pair_collector_lane_reg
// Description : One operand lane: data register plus valid bit. Load wins over
//               clear; clear drops only the valid bit, data is kept.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_pair_collector_lane_reg
    import operand_pair_collector_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= d;
            r_valid <= 1'b1;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign q     = r_data;
    assign valid = r_valid;

endmodule : operand_pair_collector_lane_reg
`default_nettype wire

// File: rtl/operand_pair_collector.sv
`default_nettype none
// ============================================================================
// Module      : operand_pair_collector
// Description : Collects sel-steered operand words into registered lanes A/B
//               and presents complete pairs over a valid/ready handshake.
//               Optional stall counter enabled by COLLECTOR_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_pair_collector
    import operand_pair_collector_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_valid,
    input  logic              out_ready
`ifdef COLLECTOR_STATS_EN
    ,
    output logic [STALL_W-1:0] stall_count
`endif
);

    logic   w_valid_a;
    logic   w_valid_b;
    state_t w_state;
    logic   w_pop;
    logic   w_acc;
    logic   w_load_a;
    logic   w_load_b;
    logic   w_ready;

    // The state register is the pair of lane valid bits held in the lanes.
    assign w_state   = state_t'({w_valid_b, w_valid_a});
    assign w_pop     = (w_state == FULL) & out_ready;
    assign w_acc     = in_valid & w_ready;

    always_comb begin
        w_ready  = 1'b0;
        w_load_a = 1'b0;
        w_load_b = 1'b0;
        case (w_state)
            EMPTY: begin
                w_ready = 1'b1;
            end
            HAVE_A: begin
                w_ready = (in_sel == SEL_B);
            end
            HAVE_B: begin
                w_ready = (in_sel == SEL_A);
            end
            FULL: begin
                w_ready = out_ready;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
        w_load_a = w_acc & (in_sel == SEL_A);
        w_load_b = w_acc & (in_sel == SEL_B);
    end

    // A pop empties both lanes unless the same cycle reloads one of them.
    operand_pair_collector_lane_reg #(.DATA_W(DATA_W)) u_lane_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load_a),
        .clear (w_pop),
        .d     (in_data),
        .q     (out_a),
        .valid (w_valid_a)
    );

    operand_pair_collector_lane_reg #(.DATA_W(DATA_W)) u_lane_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load_b),
        .clear (w_pop),
        .d     (in_data),
        .q     (out_b),
        .valid (w_valid_b)
    );

    assign in_ready  = w_ready;
    assign out_valid = (w_state == FULL);

`ifdef COLLECTOR_STATS_EN
    logic [STALL_W-1:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (in_valid && !w_ready && (r_stall_count != STALL_SAT)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule : operand_pair_collector
`default_nettype wire

// File: tb/tb_operand_pair_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_pair_collector
// Description : Directed self-checking bench for operand_pair_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_pair_collector;

    localparam int unsigned DATA_W = 24;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_valid;
    logic              out_ready;
`ifdef COLLECTOR_STATS_EN
    logic [15:0]       stall_count;
`endif

    int checks;
    int failures;

    operand_pair_collector #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef COLLECTOR_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d, input logic r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        #2;
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_a", {8'b0, out_a}, 32'h0);
        check("rst_b", {8'b0, out_b}, 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'h1);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_valid", {31'b0, out_valid}, 32'h0);
        check("idle_a", {8'b0, out_a}, 32'h0);
        check("idle_ready", {31'b0, in_ready}, 32'h1);

        // Basic pair and pop
        drive(1'b1, 1'b0, 24'h001234, 1'b0);
        check("pair_ready_a", {31'b0, in_ready}, 32'h1);
        tick();
        drive(1'b1, 1'b1, 24'hABCDEF, 1'b0);
        check("pair_a_early", {8'b0, out_a}, 32'h001234);
        check("pair_half_valid", {31'b0, out_valid}, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        check("pair_valid", {31'b0, out_valid}, 32'h1);
        check("pair_a", {8'b0, out_a}, 32'h001234);
        check("pair_b", {8'b0, out_b}, 32'hABCDEF);
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        check("pop_valid", {31'b0, out_valid}, 32'h0);
        check("pop_stale_a", {8'b0, out_a}, 32'h001234);

        // Duplicate lane stalls
        drive(1'b1, 1'b0, 24'h000011, 1'b0);
        tick();
        drive(1'b1, 1'b0, 24'h000055, 1'b0);
        check("dup_ready", {31'b0, in_ready}, 32'h0);
        tick();
        check("dup_a_held", {8'b0, out_a}, 32'h000011);
        check("dup_valid", {31'b0, out_valid}, 32'h0);
        drive(1'b1, 1'b1, 24'h000077, 1'b0);
        check("dup_ready_b", {31'b0, in_ready}, 32'h1);
        tick();
        drive(1'b1, 1'b1, 24'h000099, 1'b0);
        check("full_valid", {31'b0, out_valid}, 32'h1);
        check("full_b", {8'b0, out_b}, 32'h000077);

        // Backpressure then pop with simultaneous load
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", {31'b0, in_ready}, 32'h0);
            tick();
            check("bp_valid", {31'b0, out_valid}, 32'h1);
            check("bp_b", {8'b0, out_b}, 32'h000077);
        end
        drive(1'b1, 1'b1, 24'h0000AA, 1'b1);
        check("sim_ready", {31'b0, in_ready}, 32'h1);
        tick();
        drive(1'b1, 1'b1, 24'h0000CC, 1'b0);
        check("sim_valid", {31'b0, out_valid}, 32'h0);
        check("sim_b", {8'b0, out_b}, 32'h0000AA);
        check("sim_a_stale", {8'b0, out_a}, 32'h000011);
        check("haveb_ready_b", {31'b0, in_ready}, 32'h0);
        drive(1'b1, 1'b0, 24'h0000CC, 1'b0);
        check("haveb_ready_a", {31'b0, in_ready}, 32'h1);

        // Asynchronous reset mid-pair
        drive(1'b1, 1'b1, 24'h0000BB, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        check("mid_rst_b", {8'b0, out_b}, 32'h0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'h1);
        #1;
        rst_n = 1'b1;
        tick();
        drive(1'b0, 1'b0, 24'h0000DD, 1'b0);
        check("post_rst_b", {8'b0, out_b}, 32'h0000BB);
        check("post_rst_valid", {31'b0, out_valid}, 32'h0);
        tick();
        check("idle_sel_a", {8'b0, out_a}, 32'h0);
        check("idle_sel_valid", {31'b0, out_valid}, 32'h0);

`ifdef COLLECTOR_STATS_EN
        check("stats_zero", {16'b0, stall_count}, 32'h0);
        drive(1'b1, 1'b1, 24'h0000EE, 1'b0);
        repeat (4) tick();
        check("stats_four", {16'b0, stall_count}, 32'h4);
        repeat (65530) tick();
        check("stats_fffe", {16'b0, stall_count}, 32'hFFFE);
        repeat (3) tick();
        check("stats_sat", {16'b0, stall_count}, 32'hFFFF);
        drive(1'b0, 1'b0, '0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_operand_pair_collector
`default_nettype wire
